// File: rtl/param_acc_cpu_if.sv
// param_acc_cpu_if: single-port memory bus between the accumulator CPU and its memory.
//   mem_rd/mem_wr : read / write request, held until an edge samples mem_ready=1
//   mem_addr      : request address
//   mem_wdata     : write data
//   mem_rdata     : read data, valid on the edge where mem_ready=1
//   mem_ready     : memory completes the pending request on this edge
interface param_acc_cpu_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/param_acc_cpu.sv
// param_acc_cpu: parametrised accumulator CPU with ready-handshaked memory,
// carry flag, unconditional jump and halt.
//   clk     : clock, all state changes on the rising edge
//   clr     : asynchronous active-low reset
//   mem     : memory bus (master side), see param_acc_cpu_if
//   ac_out  : accumulator
//   pc_out  : program counter
//   carry   : carry flag
//   halted  : high while in HALT
module param_acc_cpu #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  param_acc_cpu_if.master   mem,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              carry,
  output logic              halted
);
  localparam int unsigned OP_W  = 3;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_W-1:0] OP_ASHL  = 3'd1;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV2  = 3'd3;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd4;
  localparam logic [OP_W-1:0] OP_STORE = 3'd5;
  localparam logic [OP_W-1:0] OP_COMP  = 3'd6;
  localparam logic [OP_W-1:0] OP_JMPH  = 3'd7;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, HALT} stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD, arQ, arD;
  logic [DATA_W-1:0] irQ, irD, drQ, drD, acQ, acD;
  logic              carryQ, carryD;
  logic              rdQ, rdD, wrQ, wrD, haltedQ, haltedD;
  logic              indirect;
  logic [OP_W-1:0]   opcode;

  assign indirect = irQ[DATA_W-1];
  assign opcode   = irQ[DATA_W-2 -: OP_W];

  // Next state, datapath updates and next-cycle request lines
  always_comb begin
    stateD  = stateQ;
    pcD     = pcQ;
    arD     = arQ;
    irD     = irQ;
    drD     = drQ;
    acD     = acQ;
    carryD  = carryQ;

    case (stateQ)
      T0: begin
        arD    = pcQ;
        stateD = T1;
      end
      T1: begin
        if (mem.mem_ready) begin
          irD    = mem.mem_rdata;
          pcD    = pcQ + ADDR_W'(1);
          stateD = T2;
        end
      end
      T2: begin
        arD    = irQ[ADDR_W-1:0];
        stateD = T3;
      end
      T3: begin
        if (opcode == OP_JMPH) begin
          if (indirect) begin
            stateD = HALT;
          end else begin
            pcD    = arQ;
            stateD = T0;
          end
        end else if (indirect) begin
          if (mem.mem_ready) begin
            arD    = mem.mem_rdata[ADDR_W-1:0];
            stateD = T4;
          end
        end else begin
          stateD = T4;
        end
      end
      T4: begin
        if (mem.mem_ready) begin
          if (opcode == OP_STORE) begin
            stateD = T0;
          end else begin
            drD    = mem.mem_rdata;
            stateD = T5;
          end
        end
      end
      T5: begin
        case (opcode)
          OP_ADD:  {carryD, acD} = SUM_W'(acQ) + SUM_W'(drQ);
          OP_ASHL: begin
            carryD = acQ[DATA_W-1];
            acD    = {acQ[DATA_W-2:0], 1'b0};
          end
          OP_XNOR: acD = ~(acQ ^ drQ);
          OP_DIV2: begin
            carryD = acQ[0];
            acD    = {acQ[DATA_W-1], acQ[DATA_W-1:1]};
          end
          OP_LOAD: acD = drQ;
          OP_COMP: acD = ~drQ + DATA_W'(1);
          default: acD = acQ;
        endcase
        stateD = T0;
      end
      HALT:    stateD = HALT;
      default: stateD = T0;
    endcase

    // Requests are registered, so they are decoded from the state being entered
    rdD     = (stateD == T1) ||
              ((stateD == T3) && indirect && (opcode != OP_JMPH)) ||
              ((stateD == T4) && (opcode != OP_STORE));
    wrD     = (stateD == T4) && (opcode == OP_STORE);
    haltedD = (stateD == HALT);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stateQ  <= T0;
      pcQ     <= '0;
      arQ     <= '0;
      irQ     <= '0;
      drQ     <= '0;
      acQ     <= '0;
      carryQ  <= 1'b0;
      rdQ     <= 1'b0;
      wrQ     <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      arQ     <= arD;
      irQ     <= irD;
      drQ     <= drD;
      acQ     <= acD;
      carryQ  <= carryD;
      rdQ     <= rdD;
      wrQ     <= wrD;
      haltedQ <= haltedD;
    end
  end

  assign mem.mem_rd    = rdQ;
  assign mem.mem_wr    = wrQ;
  assign mem.mem_addr  = arQ;
  assign mem.mem_wdata = acQ;
  assign ac_out        = acQ;
  assign pc_out        = pcQ;
  assign carry         = carryQ;
  assign halted        = haltedQ;
endmodule

// File: doc/param_acc_cpu.md
Name: param_acc_cpu

Overview:
- Parametrised accumulator CPU, next generation of the team's 8-bit/4-bit-address accumulator core.
- Data width and address width are set by parameters.
- Adds a ready-based memory handshake (wait states), a carry flag register, an unconditional jump, and a halt state.
- Sits between the testbench/SoC memory model and nothing else; it is the only master on the single-port memory.

Parameters:
- DATA_W, 8, accumulator/data/instruction word width; must satisfy DATA_W >= ADDR_W+4.
- ADDR_W, 4, memory address width; PC and AR width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-low.
- mem_rd  output  1  read request; held until a rising edge samples mem_ready=1.
- mem_wr  output  1  write request; held until a rising edge samples mem_ready=1.
- mem_addr  output  ADDR_W  address (equals AR).
- mem_wdata  output  DATA_W  write data (equals AC).
- mem_rdata  input  DATA_W  read data; valid on the edge where mem_ready=1.
- mem_ready  input  1  memory completes the current request on this edge.
- ac_out  output  DATA_W  accumulator.
- pc_out  output  ADDR_W  program counter.
- carry  output  1  carry flag.
- halted  output  1  high while in HALT.

Behaviour:
- Instruction format: bit DATA_W-1 = I (indirect), bits DATA_W-2:DATA_W-4 = opcode, bits ADDR_W-1:0 = address. Unused middle bits are ignored.
- Reset (clr=0, async): state=T0; PC, AR, IR, DR, AC, carry all 0; mem_rd=mem_wr=halted=0. Reset mid-wait aborts the request immediately, with no write committed.
- States and actions (one edge each unless waiting):
  - T0: AR<=PC.
  - T1: mem_rd=1; on ready, IR<=rdata, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0).
  - T2: AR<=IR address field.
  - T3, opcode 7 with I=0 (JMP): PC<=AR, go T0.
  - T3, opcode 7 with I=1 (HLT): go HALT.
  - T3, other opcodes with I=1: mem_rd=1; on ready, AR<=rdata[ADDR_W-1:0], go T4.
  - T3, other opcodes with I=0: one idle cycle, go T4.
  - T4, STORE (5): mem_wr=1; on ready, go T0.
  - T4, other opcodes: mem_rd=1; on ready, DR<=rdata, go T5.
  - T5: AC<=ALU result, go T0.
  - HALT: no requests, all registers frozen; exit only via reset.
- ALU (T5), width DATA_W:
  - 0 ADD: {carry,AC}<=AC+DR.
  - 1 ASHL: carry<=AC[MSB], AC<=AC<<1.
  - 2 XNOR: AC<=~(AC^DR).
  - 3 DIV2: AC<=arithmetic shift right of AC (sign kept); carry<=AC[0].
  - 4 LOAD: AC<=DR.
  - 6 COMP2S: AC<=~DR+1.
  - carry is unchanged except by ADD, ASHL and DIV2.
- Latency with mem_ready tied high:
  - ALU ops: 6 cycles.
  - STORE: 5 cycles.
  - JMP: 4 cycles.
  - Indirect does not add cycles, since T3 is always one cycle.
  - Each low mem_ready cycle during a request adds exactly one cycle.
- mem_rd and mem_wr are never both high. The request signals, mem_addr and mem_wdata are stable while waiting.
- mem_ready sampled outside a request is ignored.

Test Plan:
- Reset/defaults: clr=0 mid-T4 read with mem_ready=0 -> all outputs 0 immediately; after release, first mem_rd at address 0 in cycle 2.
- Direct program (DATA_W=8, ADDR_W=4): mem[0]=0x49 (LOAD 9), mem[1]=0x0A (ADD 10), mem[2]=0x5B (STORE 11), mem[3]=0xF0 (HLT), mem[9]=0x7F, mem[10]=0x82, mem_ready=1 -> mem[11]=0x01, carry=1, halted=1 after 6+6+5+4=21 cycles, pc_out=4.
- Indirect + wait states: mem[0]=0xC5 (LOAD I 5), mem[5]=0x0E, mem[14]=0xA5; mem_ready low for 2 cycles on every request -> AC=0xA5 after 6+3×2=12 cycles.
- JMP/wrap: mem[15]=0x70 (JMP 0) with PC starting at 15 -> PC wraps to 0 at T1, then the JMP sets PC=0; 4 cycles per JMP; loop repeats indefinitely with halted=0.
- ALU ops on AC=0x81, DR=0x81:
  - ASHL -> AC=0x02, carry=1.
  - DIV2 on 0x81 -> AC=0xC0, carry=1.
  - XNOR -> AC=0xFF.
  - COMP2S on DR=0x01 -> AC=0xFF.
- Parameter sweep DATA_W=16, ADDR_W=8: LOAD/ADD/STORE program at addresses 0xF0..0xFF -> correct 16-bit sum; PC wraps 0xFF->0x00.
